// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline encodings: ALU operations, forwarding selects and
// result-source selects.
package riscv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational RV32I ALU with zero flag; unsupported operation codes yield 0.
module alu
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      ALU_ADD: ALUResult = SrcA + SrcB;
      ALU_SUB: ALUResult = SrcA - SrcB;
      ALU_AND: ALUResult = SrcA & SrcB;
      ALU_OR:  ALUResult = SrcA | SrcB;
      ALU_SLT: ALUResult = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the 5-stage RV32I pipeline: ID/EX register, forwarding
// muxes, ALU, branch/jump resolution and EX/MEM register.
module execute_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [REGW-1:0] Rs1D,
  input  logic [REGW-1:0] Rs2D,
  input  logic [REGW-1:0] RdD,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            StallE,
  input  logic            FlushE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [REGW-1:0] Rs1E,
  output logic [REGW-1:0] Rs2E,
  output logic [REGW-1:0] RdE,
  output logic            ResultSrcE0,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [REGW-1:0] RdM
);

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc_plus4;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] pc_plus4;
  } exmem_t;

  idex_t           idex_d, idex_q;
  exmem_t          exmem_d, exmem_q;
  logic [XLEN-1:0] src_a, src_b, write_data_e, alu_result_e;
  logic            zero_e;

  // Flush outranks stall so a simultaneous request always yields a bubble.
  always_comb begin
    idex_d = idex_q;
    if (FlushE) begin
      idex_d = '0;
    end else if (!StallE) begin
      idex_d.reg_write   = RegWriteD;
      idex_d.mem_write   = MemWriteD;
      idex_d.jump        = JumpD;
      idex_d.branch      = BranchD;
      idex_d.alu_src     = ALUSrcD;
      idex_d.result_src  = ResultSrcD;
      idex_d.alu_control = ALUControlD;
      idex_d.rd1         = RD1D;
      idex_d.rd2         = RD2D;
      idex_d.pc          = PCD;
      idex_d.imm_ext     = ImmExtD;
      idex_d.pc_plus4    = PCPlus4D;
      idex_d.rs1         = Rs1D;
      idex_d.rs2         = Rs2D;
      idex_d.rd          = RdD;
    end
  end

  always_comb begin
    case (ForwardAE)
      FWD_W:   src_a = ResultW;
      FWD_M:   src_a = exmem_q.alu_result;
      default: src_a = idex_q.rd1;
    endcase
    case (ForwardBE)
      FWD_W:   write_data_e = ResultW;
      FWD_M:   write_data_e = exmem_q.alu_result;
      default: write_data_e = idex_q.rd2;
    endcase
    src_b = idex_q.alu_src ? idex_q.imm_ext : write_data_e;
  end

  alu #(.XLEN(XLEN)) u_alu (
    .SrcA       (src_a),
    .SrcB       (src_b),
    .ALUControl (idex_q.alu_control),
    .ALUResult  (alu_result_e),
    .Zero       (zero_e)
  );

  always_comb begin
    exmem_d            = '0;
    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.result_src = idex_q.result_src;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.alu_result = alu_result_e;
    exmem_d.write_data = write_data_e;
    exmem_d.rd         = idex_q.rd;
    exmem_d.pc_plus4   = idex_q.pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
    end
  end

  assign PCSrcE      = (idex_q.branch & zero_e) | idex_q.jump;
  assign PCTargetE   = idex_q.pc + idex_q.imm_ext;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign ResultSrcE0 = idex_q.result_src[0];

  assign RegWriteM   = exmem_q.reg_write;
  assign MemWriteM   = exmem_q.mem_write;
  assign ResultSrcM  = exmem_q.result_src;
  assign ALUResultM  = exmem_q.alu_result;
  assign WriteDataM  = exmem_q.write_data;
  assign PCPlus4M    = exmem_q.pc_plus4;
  assign RdM         = exmem_q.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Directed, table-driven bench for execute_stage plus hand-written
// reset, flush and stall sequences.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        StallE, FlushE;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        ResultSrcE0;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
    .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RdD(RdD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .StallE(StallE), .FlushE(FlushE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  typedef struct {
    logic [31:0] alu_ctl, alu_src, branch, jump, reg_write, mem_write, res_src;
    logic [31:0] rd1, rd2, pc, imm, pc4, rs1, rs2, rd;
    logic [31:0] fwda, fwdb, resw;
    logic [31:0] e_pcsrc, e_target, m_alu, m_wd;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];
  vec_t zv;
  vec_t v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_d(input vec_t x);
    ALUControlD = x.alu_ctl[2:0];
    ALUSrcD     = x.alu_src[0];
    BranchD     = x.branch[0];
    JumpD       = x.jump[0];
    RegWriteD   = x.reg_write[0];
    MemWriteD   = x.mem_write[0];
    ResultSrcD  = x.res_src[1:0];
    RD1D        = x.rd1;
    RD2D        = x.rd2;
    PCD         = x.pc;
    ImmExtD     = x.imm;
    PCPlus4D    = x.pc4;
    Rs1D        = x.rs1[4:0];
    Rs2D        = x.rs2[4:0];
    RdD         = x.rd[4:0];
  endtask

  task automatic drive_e(input vec_t x);
    ForwardAE = x.fwda[1:0];
    ForwardBE = x.fwdb[1:0];
    ResultW   = x.resw;
  endtask

  task automatic check_e(input int i);
    chk($sformatf("pcsrc_e[%0d]", i), 32'(PCSrcE), vecs[i].e_pcsrc);
    chk($sformatf("target_e[%0d]", i), PCTargetE, vecs[i].e_target);
    chk($sformatf("rs1_e[%0d]", i), 32'(Rs1E), vecs[i].rs1);
    chk($sformatf("rs2_e[%0d]", i), 32'(Rs2E), vecs[i].rs2);
    chk($sformatf("rd_e[%0d]", i), 32'(RdE), vecs[i].rd);
    chk($sformatf("ressrc0_e[%0d]", i), 32'(ResultSrcE0), 32'(vecs[i].res_src[0]));
  endtask

  task automatic check_m(input int i);
    chk($sformatf("alu_m[%0d]", i), ALUResultM, vecs[i].m_alu);
    chk($sformatf("wdata_m[%0d]", i), WriteDataM, vecs[i].m_wd);
    chk($sformatf("regwrite_m[%0d]", i), 32'(RegWriteM), vecs[i].reg_write);
    chk($sformatf("memwrite_m[%0d]", i), 32'(MemWriteM), vecs[i].mem_write);
    chk($sformatf("ressrc_m[%0d]", i), 32'(ResultSrcM), vecs[i].res_src);
    chk($sformatf("rd_m[%0d]", i), 32'(RdM), vecs[i].rd);
    chk($sformatf("pc4_m[%0d]", i), PCPlus4M, vecs[i].pc4);
    chk($sformatf("no_x[%0d]", i), 32'($isunknown({PCSrcE, PCTargetE, Rs1E, Rs2E, RdE,
        ResultSrcE0, RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM,
        PCPlus4M, RdM})), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // alu_ctl alu_src br jmp rw mw rs | rd1 rd2 pc imm pc4 | rs1 rs2 rd | fa fb rw | pcsrc target alu wd
    vecs[0]  = '{1, 0, 0, 0, 1, 0, 0, 5, 7, 'h40, 4, 'h44, 1, 2, 3, 0, 0, 0, 0, 'h44, 'hFFFFFFFE, 7};
    vecs[1]  = '{5, 0, 0, 0, 1, 0, 0, 'hFFFFFFFF, 1, 'h44, 8, 'h48, 4, 5, 6, 0, 0, 0, 0, 'h4C, 1, 1};
    vecs[2]  = '{0, 0, 0, 0, 1, 0, 0, 4, 6, 'h48, 0, 'h4C, 2, 3, 1, 0, 0, 0, 0, 'h48, 10, 6};
    vecs[3]  = '{0, 0, 0, 0, 1, 0, 0, 99, 3, 'h4C, 0, 'h50, 1, 4, 7, 2, 0, 0, 0, 'h4C, 13, 3};
    vecs[4]  = '{0, 0, 0, 0, 0, 1, 0, 20, 77, 'h50, 0, 'h54, 8, 9, 0, 0, 1, 4, 0, 'h50, 24, 4};
    vecs[5]  = '{1, 0, 1, 0, 0, 0, 0, 8, 8, 'h100, 'hFFFFFFF0, 'h104, 10, 11, 0, 0, 0, 0, 1, 'hF0, 0, 8};
    vecs[6]  = '{1, 0, 1, 0, 0, 0, 0, 8, 9, 'h100, 'hFFFFFFF0, 'h104, 10, 12, 0, 0, 0, 0, 0, 'hF0, 'hFFFFFFFF, 9};
    vecs[7]  = '{0, 0, 0, 1, 1, 0, 2, 1, 2, 'h200, 8, 'h204, 13, 14, 1, 0, 0, 0, 1, 'h208, 3, 2};
    vecs[8]  = '{7, 0, 0, 0, 1, 0, 0, 'h55, 'hAA, 'h210, 4, 'h214, 15, 16, 17, 0, 0, 0, 0, 'h214, 0, 'hAA};
    vecs[9]  = '{3, 1, 0, 0, 1, 0, 0, 5, 'h33, 0, 'h10, 4, 18, 19, 20, 0, 0, 0, 0, 'h10, 'h15, 'h33};
    vecs[10] = '{2, 0, 0, 0, 1, 0, 1, 'hF0F0, 'h0FF0, 'h20, 4, 'h24, 21, 22, 23, 0, 0, 0, 0, 'h24, 'hF0, 'h0FF0};
    vecs[11] = '{0, 0, 0, 0, 1, 0, 0, 2, 3, 'h30, 0, 'h34, 24, 25, 26, 3, 3, 100, 0, 'h30, 5, 3};
    vecs[12] = '{5, 0, 0, 0, 1, 0, 0, 1, 'hFFFFFFFF, 'h40, 0, 'h44, 27, 28, 29, 0, 0, 0, 0, 'h40, 0, 'hFFFFFFFF};
    zv = '{default: '0};

    // Reset held two cycles with a live jump on the D inputs.
    reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    v = vecs[0]; v.jump = 1; v.mem_write = 1; v.res_src = 2;
    drive_d(v); drive_e(zv);
    step(); step();
    chk("rst_pcsrc", 32'(PCSrcE), 0);
    chk("rst_rd_e", 32'(RdE), 0);
    chk("rst_rs1_e", 32'(Rs1E), 0);
    chk("rst_regwrite_m", 32'(RegWriteM), 0);
    chk("rst_memwrite_m", 32'(MemWriteM), 0);
    chk("rst_ressrc_m", 32'(ResultSrcM), 0);
    chk("rst_alu_m", ALUResultM, 0);
    chk("rst_wdata_m", WriteDataM, 0);
    chk("rst_pc4_m", PCPlus4M, 0);
    chk("rst_rd_m", 32'(RdM), 0);
    reset = 1'b0;

    // Iteration i loads row i into E and captures row i-1 into M.
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      drive_d(i < NV ? vecs[i] : zv);
      drive_e(i > 0 ? vecs[i-1] : zv);
      #1;
      if (i > 0) check_e(i - 1);
      step();
      if (i > 0) check_m(i - 1);
    end
    drive_e(zv);

    // Flush of a load: bubble in E, no write reaching M.
    v = zv; v.reg_write = 1; v.res_src = 1; v.rd = 5; v.rs1 = 6; v.jump = 1;
    drive_d(v); FlushE = 1'b1;
    step();
    chk("flush_ressrc0_e", 32'(ResultSrcE0), 0);
    chk("flush_rd_e", 32'(RdE), 0);
    chk("flush_rs1_e", 32'(Rs1E), 0);
    chk("flush_pcsrc", 32'(PCSrcE), 0);
    FlushE = 1'b0; drive_d(zv);
    step();
    chk("flush_regwrite_m", 32'(RegWriteM), 0);
    chk("flush_memwrite_m", 32'(MemWriteM), 0);
    chk("flush_rd_m", 32'(RdM), 0);

    // Stall holds E for two cycles while EX/MEM keeps capturing.
    v = zv; v.jump = 1; v.rd = 7; v.rs1 = 8; v.rs2 = 9; v.pc = 'h300; v.imm = 'h20;
    v.reg_write = 1; v.pc4 = 'h304;
    drive_d(v);
    step();
    chk("stall_load_rd_e", 32'(RdE), 7);
    v = zv; v.rd = 2; v.rs1 = 3; v.pc = 'h10; v.jump = 1;
    drive_d(v); StallE = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stall_rd_e", 32'(RdE), 7);
      chk("stall_rs1_e", 32'(Rs1E), 8);
      chk("stall_rs2_e", 32'(Rs2E), 9);
      chk("stall_target_e", PCTargetE, 'h320);
      chk("stall_pcsrc", 32'(PCSrcE), 1);
      chk("stall_rd_m", 32'(RdM), 7);
      chk("stall_pc4_m", PCPlus4M, 'h304);
    end

    // Flush and stall together: flush wins.
    FlushE = 1'b1;
    step();
    chk("fs_rd_e", 32'(RdE), 0);
    chk("fs_rs1_e", 32'(Rs1E), 0);
    chk("fs_pcsrc", 32'(PCSrcE), 0);
    FlushE = 1'b0; StallE = 1'b0; drive_d(zv);
    step();
    chk("fs_regwrite_m", 32'(RegWriteM), 0);
    chk("fs_rd_m", 32'(RdM), 0);

    // Reset while an instruction sits in E discards it.
    v = zv; v.reg_write = 1; v.mem_write = 1; v.rd = 9; v.rd1 = 3; v.rd2 = 4; v.pc4 = 8;
    drive_d(v);
    step();
    chk("midrst_rd_e_before", 32'(RdE), 9);
    reset = 1'b1;
    step();
    chk("midrst_regwrite_m", 32'(RegWriteM), 0);
    chk("midrst_memwrite_m", 32'(MemWriteM), 0);
    chk("midrst_alu_m", ALUResultM, 0);
    chk("midrst_wdata_m", WriteDataM, 0);
    chk("midrst_rd_m", 32'(RdM), 0);
    chk("midrst_rd_e", 32'(RdE), 0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
